// File: rtl/br_sfifo_gen.sv
// Single-clock parametrised FIFO with normal or show-ahead read port,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module br_sfifo_gen #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int PTR       = 3,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 1
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             sclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  output logic             wrfull,
  output logic             wralmfull,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             rdempty,
  output logic             rdalmempty,
  output logic [PTR:0]     usedw,
  output logic             ovf,
  output logic             udf
);

  localparam logic [PTR:0] DEPTH_W  = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] AFULL_W  = (PTR+1)'(AFULL_TH);
  localparam logic [PTR:0] AEMPTY_W = (PTR+1)'(AEMPTY_TH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR:0]     usedw_q, usedw_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_acc, rd_acc;

  // Handshake: wrreq/rdreq act as valid, ~wrfull/~rdempty act as ready; a word
  // moves only when both are high at the rising edge and sclr is low.
  assign wrfull     = (usedw_q == DEPTH_W);
  assign rdempty    = (usedw_q == '0);
  assign wralmfull  = (usedw_q >= AFULL_W);
  assign rdalmempty = (usedw_q <= AEMPTY_W);
  assign usedw      = usedw_q;
  assign ovf        = ovf_q;
  assign udf        = udf_q;

  assign wr_acc = wrreq & ~wrfull & ~sclr;
  assign rd_acc = rdreq & ~rdempty & ~sclr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (sclr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   usedw_d = usedw_q + 1'b1;
        2'b01:   usedw_d = usedw_q - 1'b1;
        default: usedw_d = usedw_q;
      endcase
      // Rejected requests are judged against the registered flags.
      ovf_d = ovf_q | (wrreq & wrfull);
      udf_d = udf_q | (rdreq & rdempty);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage has no reset; only words below usedw are ever observable.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data;
  end

  if (FWFT != 0) begin : g_fwft
    assign q = mem_q[rd_ptr_q];
  end else begin : g_norm
    logic [WIDTH-1:0] q_q;
    always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)     q_q <= '0;
      else if (sclr)   q_q <= '0;
      else if (rd_acc) q_q <= mem_q[rd_ptr_q];
    end
    assign q = q_q;
  end

endmodule

// File: doc/br_sfifo_gen.md
Name: br_sfifo_gen

Overview:
- Parametrised single-clock FIFO; next generation of the 4x32 bridge FIFO.
- Adds configurable width and depth, selectable show-ahead (FWFT) or normal read mode, almost-full and almost-empty thresholds, and sticky overflow/underflow error flags.
- Sits between LMAC core pipeline stages that share one clock domain, where the dual-clock FIFO is unnecessary overhead.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 8, number of entries; must equal 2**PTR.
- PTR, 3, address width; count and level are PTR+1 bits wide.
- FWFT, 0, read mode: 0 = normal (q updates after an accepted read); 1 = show-ahead (q presents the head word).
- AFULL_TH, 6, wralmfull asserts when usedw >= AFULL_TH.
- AEMPTY_TH, 1, rdalmempty asserts when usedw <= AEMPTY_TH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_  in  1  asynchronous, active-low reset.
- sclr  in  1  synchronous clear; same effect as reset, one cycle.
- wrreq  in  1  write request.
- data  in  WIDTH  write data.
- wrfull  out  1  FIFO full.
- wralmfull  out  1  usedw >= AFULL_TH.
- rdreq  in  1  read request.
- q  out  WIDTH  read data.
- rdempty  out  1  FIFO empty.
- rdalmempty  out  1  usedw <= AEMPTY_TH.
- usedw  out  PTR+1  entries currently stored, 0..DEPTH.
- ovf  out  1  sticky: a write was attempted while full.
- udf  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (reset_ = 0, async):
  - wr/rd pointers = 0, usedw = 0, rdempty = 1, wrfull = 0.
  - wralmfull = (AFULL_TH == 0); rdalmempty = 1.
  - ovf = udf = 0; q = 0 in normal mode.
  - Memory contents are not reset.
- sclr = 1: same state as reset at the next edge. It overrides wrreq and rdreq in that cycle; no error flags are set.
- Write acceptance: accepted iff wrreq & ~wrfull. data is stored at wrptr and wrptr increments. A write while full is dropped, sets ovf, and leaves the pointers unchanged.
- Read acceptance: accepted iff rdreq & ~rdempty; rdptr increments. A read while empty is ignored and sets udf.
- Full-gating is evaluated on registered flags. At full, simultaneous wrreq+rdreq: read accepted, write dropped, ovf set. At empty, simultaneous: write accepted, read ignored, udf set.
- usedw arithmetic:
  - +1 on an accepted write only; -1 on an accepted read only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Pointers: PTR bits, wrap DEPTH-1 -> 0 naturally.
- Flags are combinational decodes of the registered usedw, so they are valid in the same cycle:
  - wrfull = (usedw == DEPTH)
  - rdempty = (usedw == 0)
  - wralmfull and rdalmempty per their thresholds.
- FWFT = 0 (normal mode):
  - q <= mem[rdptr] on an accepted read; the word is visible one cycle after the rdreq edge.
  - q holds its value otherwise, including on reads while empty.
- FWFT = 1 (show-ahead mode):
  - q = mem[rdptr] continuously; valid whenever rdempty = 0.
  - A write into an empty FIFO appears on q, with rdempty = 0, the cycle after the write edge.
  - An accepted rdreq pops the word; the next word is on q the following cycle.
  - q is don't-care while empty.
- ovf and udf stay set until reset_ or sclr.
- Reset asserted mid-burst: all state clears immediately. The first write after release is stored at address 0.

Test Plan:
- Defaults, FWFT = 0: write 0x11..0x88 (8 words) -> wrfull = 1 after the 8th edge, usedw = 8, wralmfull from usedw = 6. Read 8 -> q = 0x11..0x88 in order, each one cycle after rdreq; rdempty = 1 at the end, ovf = udf = 0.
- Full FIFO, wrreq + rdreq together for one cycle -> usedw = 7, q = oldest word, ovf = 1, the new word is not stored.
- Empty FIFO, rdreq only -> udf = 1, usedw = 0, q unchanged. Then sclr pulse -> udf = 0.
- FWFT = 1: write 0xA5 into empty -> next cycle rdempty = 0, q = 0xA5 with no rdreq. Then continuous wrreq + rdreq for 20 cycles with usedw at 1 -> usedw stays 1 and data streams in order through the wrap-around.
- Thresholds: fill from 0 to 2 -> rdalmempty deasserts at usedw = 2. Drain from 6 to 5 -> wralmfull deasserts at usedw = 5.
- Async reset_ low mid-cycle with usedw = 5 -> immediately usedw = 0, rdempty = 1, wrfull = 0. Then write 0x3C and read it -> q = 0x3C.
